bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 154 +++++++++++++++
 tb/tb_bit_serializer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// bit_serializer: word FIFO feeding a parallel-to-serial shifter with a programmable bit period.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_data    word to serialize
//   in_valid   in_data valid
//   in_ready   FIFO can accept a word this cycle
//   div        bit period = div+1 clocks; sampled when a word is loaded
//   flush      synchronous abort of queued words and the word in flight
//   ser_out    serial bit stream
//   ser_valid  high while a word is being shifted out
//   bit_strobe one-clock pulse in the first cycle of each bit period
//   fifo_count words currently held in the FIFO
module bit_serializer #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned DIV_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DIV_W-1:0]         div,
    input  logic                     flush,
    output logic                     ser_out,
    output logic                     ser_valid,
    output logic                     bit_strobe,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned IW = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DIV_W-1:0]  timer_q, timer_d;
    logic [DIV_W-1:0]  reload_q, reload_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              ser_out_q, ser_valid_q, bit_strobe_q;
    logic              ser_out_d, ser_valid_d, bit_strobe_d;

    logic do_push, do_pop, last_clk, cur_bit;

    assign in_ready   = (count_q < CW'(DEPTH));
    assign fifo_count = count_q;
    assign ser_out    = ser_out_q;
    assign ser_valid  = ser_valid_q;
    assign bit_strobe = bit_strobe_q;

    assign do_push  = in_valid && in_ready && !flush;
    assign last_clk = (state_q == StShift) && (timer_q == '0) && (idx_q == IW'(DATA_W - 1));
    // A pop always coincides with a word load into the shifter.
    assign do_pop   = !flush && (count_q != '0) && ((state_q == StIdle) || last_clk);
    assign cur_bit  = (MSB_FIRST != 0) ? shreg_q[DATA_W-1] : shreg_q[0];

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        timer_d  = timer_q;
        reload_d = reload_q;
        idx_d    = idx_q;
        count_d  = count_q;

        if (flush) begin
            state_d = StIdle;
            shreg_d = '0;
            timer_d = '0;
            idx_d   = '0;
        end else if (do_pop) begin
            state_d  = StShift;
            shreg_d  = mem_q[rptr_q];
            reload_d = div;
            timer_d  = div;
            idx_d    = '0;
        end else if (state_q == StShift) begin
            if (timer_q == '0) begin
                if (last_clk) begin
                    state_d = StIdle;
                    shreg_d = '0;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    timer_d = reload_q;
                    shreg_d = (MSB_FIRST != 0) ? {shreg_q[DATA_W-2:0], 1'b0}
                                               : {1'b0, shreg_q[DATA_W-1:1]};
                end
            end else begin
                timer_d = timer_q - DIV_W'(1);
            end
        end

        if (flush) begin
            count_d = '0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // Outputs are registered, so the stream appears one clock after the shifter state.
        ser_valid_d  = !flush && (state_q == StShift);
        ser_out_d    = ser_valid_d && cur_bit;
        bit_strobe_d = ser_valid_d && (timer_q == reload_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            shreg_q      <= '0;
            timer_q      <= '0;
            reload_q     <= '0;
            idx_q        <= '0;
            ser_out_q    <= 1'b0;
            ser_valid_q  <= 1'b0;
            bit_strobe_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            shreg_q      <= shreg_d;
            timer_q      <= timer_d;
            reload_q     <= reload_d;
            idx_q        <= idx_d;
            ser_out_q    <= ser_out_d;
            ser_valid_q  <= ser_valid_d;
            bit_strobe_q <= bit_strobe_d;
            if (flush) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (do_push) wptr_q <= wptr_q + AW'(1);
                if (do_pop)  rptr_q <= rptr_q + AW'(1);
            end
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= in_data;
    end

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] div;
    logic       flush;
    logic       ser_out;
    logic       ser_valid;
    logic       bit_strobe;
    logic [2:0] fifo_count;

    bit_serializer #(
        .DATA_W(8), .DEPTH(4), .MSB_FIRST(1), .DIV_W(8)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .div(div), .flush(flush), .ser_out(ser_out), .ser_valid(ser_valid),
        .bit_strobe(bit_strobe), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic exp_q[$];
    logic exp_bit;
    int   checks = 0;
    int   errors = 0;
    int   vcount = 0;
    int   scount = 0;
    int   bits_seen = 0;
    int   cyc = 0;
    int   first_v = -1;
    int   last_v = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: one expected bit per strobe.
    always @(negedge clk) begin
        cyc++;
        if (rst === 1'b1 && ser_valid === 1'b1) begin
            vcount++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
            if (bit_strobe === 1'b1) begin
                scount++;
                bits_seen++;
                if (exp_q.size() == 0) begin
                    check("bit_without_expectation", 32'(ser_valid), 0);
                end else begin
                    exp_bit = exp_q.pop_front();
                    check("ser_bit", 32'(ser_out), 32'(exp_bit));
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
    endtask

    task automatic reset_stats;
        vcount = 0;
        scount = 0;
        first_v = -1;
        last_v = -1;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ser_valid || fifo_count != 0) && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 3000), 1);
        tick();
        tick();
    endtask

    task automatic wait_bits(input int target, input string tag);
        int n;
        n = 0;
        while (bits_seen < target && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, 32'(n < 500), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] words [10];
        int accepted, n, max_cnt, full_pops, base;
        logic will_push;
        logic [2:0] prevc;

        rst = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        div = '0;
        flush = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_ser_valid", 32'(ser_valid), 0);
        check("rst_ser_out", 32'(ser_out), 0);
        check("rst_bit_strobe", 32'(bit_strobe), 0);
        check("rst_fifo_count", 32'(fifo_count), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        rst = 1'b1;
        tick();

        // Single word, div=0, latency k+2
        reset_stats();
        div = 8'd0;
        in_data = 8'hB4;
        in_valid = 1'b1;
        push_expected(8'hB4);
        tick();
        in_valid = 1'b0;
        check("lat_count_k", 32'(fifo_count), 1);
        check("lat_valid_k", 32'(ser_valid), 0);
        tick();
        check("lat_valid_k1", 32'(ser_valid), 0);
        tick();
        check("lat_valid_k2", 32'(ser_valid), 1);
        check("lat_bit0_k2", 32'(ser_out), 1);
        wait_drain("drain_b4");
        check("b4_valid_cycles", 32'(vcount), 8);
        check("b4_strobes", 32'(scount), 8);

        // div=2, div changed mid-word must not matter
        reset_stats();
        div = 8'd2;
        in_data = 8'hA5;
        in_valid = 1'b1;
        push_expected(8'hA5);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        div = 8'd0;
        wait_drain("drain_a5");
        check("a5_valid_cycles", 32'(vcount), 24);
        check("a5_strobes", 32'(scount), 8);

        // Back-to-back words, contiguous stream
        reset_stats();
        div = 8'd0;
        in_valid = 1'b1;
        in_data = 8'hFF; push_expected(8'hFF); tick();
        in_data = 8'h00; push_expected(8'h00); tick();
        in_data = 8'h0D; push_expected(8'h0D); tick();
        in_valid = 1'b0;
        wait_drain("drain_b2b");
        check("b2b_valid_cycles", 32'(vcount), 24);
        check("b2b_contiguous", 32'(last_v - first_v + 1), 24);

        // Fill FIFO, pop at full, pointer wrap over 10 words
        reset_stats();
        div = 8'd3;
        for (int i = 0; i < 10; i++) words[i] = 8'(i * 37 + 5);
        accepted = 0;
        n = 0;
        max_cnt = 0;
        full_pops = 0;
        in_valid = 1'b1;
        while (accepted < 10 && n < 3000) begin
            in_data = words[accepted];
            will_push = in_ready;
            prevc = fifo_count;
            if (will_push) push_expected(in_data);
            tick();
            n++;
            if (will_push) accepted++;
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (fifo_count == 3'd4) check("in_ready_at_full", 32'(in_ready), 0);
            if (prevc == 3'd4 && fifo_count != 3'd4) begin
                check("pop_at_full_no_push", 32'(fifo_count), 3);
                full_pops++;
            end
        end
        in_valid = 1'b0;
        check("fill_accepted", 32'(accepted), 10);
        check("fill_max_count", 32'(max_cnt), 4);
        check("fill_saw_full_pop", 32'(full_pops > 0), 1);
        wait_drain("drain_fill");
        check("fill_valid_cycles", 32'(vcount), 320);

        // Flush during bit 3 with 2 words queued, concurrent push dropped
        div = 8'd0;
        in_valid = 1'b1;
        in_data = 8'h96; push_expected(8'h96); tick();
        in_data = 8'h5A; push_expected(8'h5A); tick();
        in_data = 8'hC3; push_expected(8'hC3); tick();
        in_valid = 1'b0;
        base = bits_seen - 8 * 0;
        wait_bits(base + 2, "flush_wait_bits");
        check("flush_pre_count", 32'(fifo_count), 2);
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h3C;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("flush_valid", 32'(ser_valid), 0);
        check("flush_out", 32'(ser_out), 0);
        check("flush_count", 32'(fifo_count), 0);
        reset_stats();
        repeat (12) tick();
        check("flush_no_bits", 32'(vcount), 0);
        check("flush_count_after", 32'(fifo_count), 0);

        // Asynchronous reset mid-word
        div = 8'd1;
        in_valid = 1'b1;
        in_data = 8'hE7; push_expected(8'hE7); tick();
        in_data = 8'h18; push_expected(8'h18); tick();
        in_valid = 1'b0;
        base = bits_seen;
        wait_bits(base + 6, "rst_wait_bits");
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 32'(ser_valid), 0);
        check("arst_out", 32'(ser_out), 0);
        check("arst_strobe", 32'(bit_strobe), 0);
        check("arst_count", 32'(fifo_count), 0);
        check("arst_ready", 32'(in_ready), 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        reset_stats();
        repeat (12) tick();
        check("arst_no_bits", 32'(vcount), 0);
        check("arst_ready_after", 32'(in_ready), 1);
        check("arst_count_after", 32'(fifo_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
